// File: rtl/reg_wb_arbiter.sv
// Register-file write-port arbiter: W stage first, then a queued long-latency result, then an optional direct LU grant.
// Optional feature macro LU_BYPASS_EN grants an LU result straight through when the W stage and FIFO are idle.
module reg_wb_arbiter #(
   parameter int DEPTH    = 2,
   parameter int MAX_WAIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        w_we,
   input  logic [4:0]  w_rd,
   input  logic [31:0] w_data,
   input  logic        lu_valid,
   input  logic [4:0]  lu_rd,
   input  logic [31:0] lu_data,
   output logic        lu_ready,
   input  logic        issue_valid,
   input  logic [4:0]  issue_rd,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic [31:0] pend,
   output logic        stall_req
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int SW = $clog2(MAX_WAIT + 1);

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_t;

   wb_t           mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic [SW-1:0] wait_cnt, wait_nxt;
   logic [31:0]   pend_nxt;
   logic          w_valid, lu_keep, empty, full, deq, enq, bypass, lu_grant, grant_vld;
   wb_t           head, grant;

   always_comb begin
      w_valid = w_we && (w_rd != 5'd0);
      empty   = (count == '0);
      full    = (count == CW'(DEPTH));
      // x0 results are still handshaken so the producer moves on, but are dropped here
      lu_keep = lu_valid && !full && (lu_rd != 5'd0);
      head    = mem[rd_ptr];
      deq     = !w_valid && !empty;
`ifdef LU_BYPASS_EN
      bypass  = !w_valid && empty && lu_keep;
`else
      bypass  = 1'b0;
`endif
      enq       = lu_keep && !bypass;
      lu_grant  = deq || bypass;
      grant_vld = w_valid || lu_grant;

      grant = head;
      if (w_valid) begin
         grant.rd   = w_rd;
         grant.data = w_data;
      end else if (!deq) begin
         grant.rd   = lu_rd;
         grant.data = lu_data;
      end

      wait_nxt = wait_cnt;
      if (empty || deq)
         wait_nxt = '0;
      else if (wait_cnt != SW'(MAX_WAIT))
         wait_nxt = wait_cnt + SW'(1);

      // clear before set so an issue racing the retiring write keeps the bit
      pend_nxt = pend;
      if (lu_grant)
         pend_nxt[grant.rd] = 1'b0;
      if (issue_valid && (issue_rd != 5'd0))
         pend_nxt[issue_rd] = 1'b1;
      pend_nxt[0] = 1'b0;
   end

   assign lu_ready = !full;

   always_ff @(posedge clk) begin
      if (enq)
         mem[wr_ptr] <= '{rd: lu_rd, data: lu_data};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rf_we     <= 1'b0;
         rf_waddr  <= '0;
         rf_wdata  <= '0;
         pend      <= '0;
         stall_req <= 1'b0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         wait_cnt  <= '0;
      end else begin
         rf_we <= grant_vld;
         if (grant_vld) begin
            rf_waddr <= grant.rd;
            rf_wdata <= grant.data;
         end
         if (enq)
            wr_ptr <= wr_ptr + AW'(1);
         if (deq)
            rd_ptr <= rd_ptr + AW'(1);
         count     <= count + CW'(enq) - CW'(deq);
         wait_cnt  <= wait_nxt;
         stall_req <= (wait_nxt == SW'(MAX_WAIT));
         pend      <= pend_nxt;
      end
   end
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter (DEPTH=2, MAX_WAIT=4); LU result latency depends on LU_BYPASS_EN.
module tb_reg_wb_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic        w_we;
   logic [4:0]  w_rd;
   logic [31:0] w_data;
   logic        lu_valid;
   logic [4:0]  lu_rd;
   logic [31:0] lu_data;
   logic        lu_ready;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [31:0] pend;
   logic        stall_req;

   int nerr = 0;
   int nchk = 0;

   reg_wb_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
      .clk(clk), .rst(rst),
      .w_we(w_we), .w_rd(w_rd), .w_data(w_data),
      .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .pend(pend), .stall_req(stall_req)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; w_we = 1'b1; w_rd = 5'd5; w_data = 32'h5555;
      lu_valid = 1'b0; lu_rd = '0; lu_data = '0;
      issue_valid = 1'b0; issue_rd = '0;
      tick(); tick();
      check("rst_rf_we", 32'(rf_we), 32'd0);
      check("rst_waddr", 32'(rf_waddr), 32'd0);
      check("rst_wdata", rf_wdata, 32'd0);
      check("rst_pend", pend, 32'd0);
      check("rst_stall", 32'(stall_req), 32'd0);
      check("rst_lu_ready", 32'(lu_ready), 32'd1);

      // W stage only, then x0 drop
      rst = 1'b0; w_we = 1'b1; w_rd = 5'd3; w_data = 32'h1234;
      tick();
      check("w_rf_we", 32'(rf_we), 32'd1);
      check("w_waddr", 32'(rf_waddr), 32'd3);
      check("w_wdata", rf_wdata, 32'h1234);
      w_rd = 5'd0;
      tick();
      check("w_x0_rf_we", 32'(rf_we), 32'd0);
      w_we = 1'b0;

      // LU result to x7 after issue
      issue_valid = 1'b1; issue_rd = 5'd7;
      tick();
      check("issue7_pend", pend, 32'h80);
      issue_valid = 1'b0;
      lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'hAA;
      tick();
`ifdef LU_BYPASS_EN
      check("byp_rf_we", 32'(rf_we), 32'd1);
      check("byp_waddr", 32'(rf_waddr), 32'd7);
      check("byp_wdata", rf_wdata, 32'hAA);
      check("byp_pend", pend, 32'h0);
      lu_valid = 1'b0;
      tick();
      check("byp_after_rf_we", 32'(rf_we), 32'd0);
`else
      check("lu_q_rf_we", 32'(rf_we), 32'd0);
      check("lu_q_pend", pend, 32'h80);
      lu_valid = 1'b0;
      tick();
      check("lu_rf_we", 32'(rf_we), 32'd1);
      check("lu_waddr", 32'(rf_waddr), 32'd7);
      check("lu_wdata", rf_wdata, 32'hAA);
      check("lu_pend", pend, 32'h0);
`endif

      // contention: W writes x1 every cycle while LU offers x8, x9, x10
      w_we = 1'b1; w_rd = 5'd1; w_data = 32'h11;
      issue_valid = 1'b1; issue_rd = 5'd8; tick();
      issue_rd = 5'd9; tick();
      issue_rd = 5'd10; tick();
      issue_valid = 1'b0;
      check("cont_pend", pend, 32'h700);
      lu_valid = 1'b1; lu_rd = 5'd8; lu_data = 32'h808;
      tick();
      check("cont_waddr_w", 32'(rf_waddr), 32'd1);
      check("cont_ready1", 32'(lu_ready), 32'd1);
      lu_rd = 5'd9; lu_data = 32'h909;
      tick();
      check("cont_full", 32'(lu_ready), 32'd0);
      lu_rd = 5'd10; lu_data = 32'hA0A;
      tick();
      check("cont_full_hold", 32'(lu_ready), 32'd0);
      check("cont_w_wins", 32'(rf_waddr), 32'd1);
      check("cont_no_stall", 32'(stall_req), 32'd0);
      w_we = 1'b0;
      tick();
      check("cont_wr8_we", 32'(rf_we), 32'd1);
      check("cont_wr8_addr", 32'(rf_waddr), 32'd8);
      check("cont_wr8_data", rf_wdata, 32'h808);
      check("cont_wr8_pend", pend, 32'h600);
      check("cont_ready2", 32'(lu_ready), 32'd1);
      tick();
      lu_valid = 1'b0;
      check("cont_wr9_addr", 32'(rf_waddr), 32'd9);
      check("cont_wr9_data", rf_wdata, 32'h909);
      check("cont_wr9_pend", pend, 32'h400);
      tick();
      check("cont_wr10_addr", 32'(rf_waddr), 32'd10);
      check("cont_wr10_data", rf_wdata, 32'hA0A);
      check("cont_wr10_pend", pend, 32'h0);
      tick();
      check("cont_idle", 32'(rf_we), 32'd0);

      // starvation: x12 queued behind a continuous W stream
      w_we = 1'b1; w_rd = 5'd2; w_data = 32'h22;
      issue_valid = 1'b1; issue_rd = 5'd12;
      lu_valid = 1'b1; lu_rd = 5'd12; lu_data = 32'hC0C;
      tick();
      issue_valid = 1'b0; lu_valid = 1'b0;
      check("starv_pend", pend, 32'h1000);
      check("starv_w", 32'(rf_waddr), 32'd2);
      tick(); tick(); tick();
      check("starv_3", 32'(stall_req), 32'd0);
      tick();
      check("starv_4", 32'(stall_req), 32'd1);
      tick();
      check("starv_sat", 32'(stall_req), 32'd1);
      check("starv_w_still", 32'(rf_waddr), 32'd2);
      w_we = 1'b0;
      tick();
      check("starv_deq_addr", 32'(rf_waddr), 32'd12);
      check("starv_deq_data", rf_wdata, 32'hC0C);
      check("starv_clear", 32'(stall_req), 32'd0);
      check("starv_pend0", pend, 32'h0);

      // scoreboard race: re-issue x6 while its queued write retires
      issue_valid = 1'b1; issue_rd = 5'd6;
      w_we = 1'b1; w_rd = 5'd2;
      tick();
      issue_valid = 1'b0;
      lu_valid = 1'b1; lu_rd = 5'd6; lu_data = 32'h66;
      tick();
      lu_valid = 1'b0; w_we = 1'b0;
      issue_valid = 1'b1; issue_rd = 5'd6;
      tick();
      check("race_addr", 32'(rf_waddr), 32'd6);
      check("race_pend", pend, 32'h40);
      issue_rd = 5'd0;
      tick();
      check("issue_x0_pend", pend, 32'h40);
      issue_valid = 1'b0;

      // LU result to x0 is accepted and dropped
      lu_valid = 1'b1; lu_rd = 5'd0; lu_data = 32'hDEAD;
      tick();
      lu_valid = 1'b0;
      check("lu_x0_we", 32'(rf_we), 32'd0);
      check("lu_x0_ready", 32'(lu_ready), 32'd1);
      tick();
      check("lu_x0_not_queued", 32'(rf_we), 32'd0);

      // reset mid-operation discards the queued x13
      w_we = 1'b1; w_rd = 5'd4; w_data = 32'h44;
      lu_valid = 1'b1; lu_rd = 5'd13; lu_data = 32'hD;
      tick();
      rst = 1'b1; w_we = 1'b0; lu_valid = 1'b0;
      tick();
      check("mid_rst_we", 32'(rf_we), 32'd0);
      check("mid_rst_pend", pend, 32'h0);
      rst = 1'b0;
      tick();
      check("mid_rst_discard", 32'(rf_we), 32'd0);
      check("mid_rst_ready", 32'(lu_ready), 32'd1);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
